sync_fifo_p: RTL and testbench
==============================

# sync_fifo_p

Parametrised single-clock FIFO; the general-purpose successor to the fixed 8-bit FIFO used between the command producer and the LCD controller. Adds configurable data width and depth, a first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Instantiated wherever a producer and consumer share `clk` but need rate decoupling.

## Interface
- `DATA_W`, 8: data word width in bits.
- `ADDR_W`, 3: pointer width; depth = 2**ADDR_W.
- `FWFT`, 0: 0 = standard registered read; 1 = head word presented on `rd_data` without a read request.
- `AF_LEVEL`, 2**ADDR_W-1: `almost_full` asserted when count >= AF_LEVEL.
- `AE_LEVEL`, 1: `almost_empty` asserted when count <= AE_LEVEL.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `flush` in 1: synchronous clear of contents; error flags kept.
- `wr_en` in 1: write request.
- `wr_data` in DATA_W: write word.
- `rd_en` in 1: read (pop) request.
- `rd_data` out DATA_W: read word.
- `rd_valid` out 1: `rd_data` holds a valid word (see Operation).
- `empty`, `full` out 1: occupancy flags.
- `almost_empty`, `almost_full` out 1: threshold flags.
- `count` out ADDR_W+1: words stored, 0..2**ADDR_W.
- `overflow`, `underflow` out 1: sticky error flags.
- `clr_err` in 1: clears both sticky flags.

## Operation
- Write accepted: `wr_en && (!full || rd_acc)`. Read accepted (`rd_acc`): `rd_en && !empty`.
- `wr_en` while full with no accepted read: word dropped, `overflow` set. `rd_en` while empty: no pop, `underflow` set.
- Full and both requests asserted: both accepted; count unchanged; new word lands in the freed slot.
- Empty and both requests asserted: write accepted, read rejected, `underflow` set.
- Pointers wrap modulo 2**ADDR_W; count carries one extra bit so full and empty are distinct.
- All flags are registered and computed from the next-state count, so they are exact in the same cycle as `count`.
- Standard mode (FWFT=0): an accepted read loads `rd_data` from the head on that edge; `rd_valid` is high for exactly that next cycle. With no accepted read, `rd_data` holds its value and `rd_valid` is 0.
- FWFT mode (FWFT=1): `rd_data` shows the head word whenever `!empty`; `rd_valid` = `!empty`; `rd_en` pops the head. `rd_data` is don't-care when empty.
- `flush` takes priority over `wr_en` and `rd_en`: pointers and count go to 0, `empty` = 1. Writes and reads in that cycle are ignored and set no error flag.
- `clr_err` clears the sticky flags. If a new error occurs in the same cycle, that flag stays set.

## Timing
- Reset values: `count` 0, `empty` 1, `almost_empty` 1, `full` 0, `almost_full` 0 (1 if AF_LEVEL = 0), `overflow` 0, `underflow` 0, `rd_valid` 0, `rd_data` 0.
- Reset mid-operation discards all contents; it overrides `flush`, `wr_en` and `rd_en`.
- Write to flag latency: one cycle (a write at edge N updates `count`/flags after edge N).
- Standard read latency: one cycle from accepted `rd_en` to `rd_data`/`rd_valid`.
- FWFT write-to-visible latency: one cycle; a word written into an empty FIFO appears on `rd_data` with `empty` = 0 after the write edge.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package `fifo_pkg`: mode constants `FIFO_STD` = 0 and `FIFO_FWFT` = 1, plus a function computing pointer width from depth.
- One sub-module, `fifo_mem`: simple dual-port array with synchronous write and asynchronous read, parametrised by DATA_W/ADDR_W.
- The top-level holds pointers, count, flags and the read register.

## Test plan
- Reset, then 8 writes of 0x10..0x17 (DATA_W=8, ADDR_W=3) -> `count` goes 1..8; `full` = 1 after 8th; `almost_full` = 1 after 7th; `empty` = 0 after 1st.
- Standard mode, full FIFO, 8 reads -> `rd_data` = 0x10..0x17 each one cycle after `rd_en` with `rd_valid` = 1; `empty` = 1 after the last read.
- Full FIFO, `wr_en` = `rd_en` = 1 with data 0xAA -> `count` stays 8, no `overflow`; 0xAA is read out 8th.
- Write while full without read -> `overflow` = 1 and stays; read while empty -> `underflow` = 1; `clr_err` pulse -> both 0.
- FWFT=1: write 0x5A into empty FIFO -> next cycle `rd_data` = 0x5A, `rd_valid` = 1, no `rd_en` needed; pop -> `empty` = 1.
- Fill 5 words, assert `flush` with `wr_en` = 1 -> `count` 0, `empty` 1, no error flags; assert `rst` mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family: read-mode constants
// and a pointer-width helper.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Smallest pointer width that can address `depth` entries (at least one bit).
    function automatic int fifo_ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_p.sv
// Parametrised single-clock FIFO with optional first-word-fall-through output,
// threshold flags, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_p
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int FWFT     = FIFO_STD,
    parameter int AF_LEVEL = 2**ADDR_W - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int              DEPTH = 2**ADDR_W;
    localparam int              PTR_W = fifo_ptr_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_LEVEL);

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic [DATA_W-1:0] head;
    logic              rd_acc, wr_acc;
    logic              ovf_evt, unf_evt;

    // A full FIFO still takes a write when a read frees the head slot the same cycle.
    assign rd_acc  = rd_en && !empty;
    assign wr_acc  = wr_en && (!full || rd_acc);
    assign ovf_evt = !flush && wr_en && !wr_acc;
    assign unf_evt = !flush && rd_en && empty;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
        end
    end

    fifo_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc && !flush),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(rd_ptr),
        .rdata(head)
    );

    // Flags are derived from the next count so they line up with `count` itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
                if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_L);
            almost_empty <= (count_nxt <= AE_L);
            almost_full  <= (count_nxt >= AF_L);
            overflow     <= (overflow && !clr_err) || ovf_evt;
            underflow    <= (underflow && !clr_err) || unf_evt;
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign rd_data  = empty ? '0 : head;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [DATA_W-1:0] rd_reg;
        logic              rd_valid_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_reg       <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= rd_acc && !flush;
                if (rd_acc && !flush) begin
                    rd_reg <= head;
                end
            end
        end

        assign rd_data  = rd_reg;
        assign rd_valid = rd_valid_reg;
    end

endmodule

// File: tb/tb_sync_fifo_p.sv
// Self-checking bench: standard and FWFT instances driven in lockstep and
// compared against a queue-based reference model.
module tb_sync_fifo_p;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en, clr_err;
    logic [7:0] wr_data;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [3:0] s_count, f_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    logic       m_ovf, m_unf, m_rd_valid;
    logic [7:0] m_rd_data;

    always #5 clk = ~clk;

    sync_fifo_p #(.DATA_W(8), .ADDR_W(3), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    sync_fifo_p #(.DATA_W(8), .ADDR_W(3), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour: a queue of stored words, evaluated once per clock edge.
    task automatic modelUpdate();
        int  n;
        bit  racc, wacc;
        n = q.size();
        if (rst) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rd_valid = 0; m_rd_data = 8'h00;
        end else if (flush) begin
            q.delete();
            m_ovf = m_ovf && !clr_err;
            m_unf = m_unf && !clr_err;
            m_rd_valid = 0;
        end else begin
            racc = rd_en && (n > 0);
            wacc = wr_en && ((n < 8) || racc);
            m_ovf = (m_ovf && !clr_err) || (wr_en && !wacc);
            m_unf = (m_unf && !clr_err) || (rd_en && (n == 0));
            m_rd_valid = racc;
            if (racc) m_rd_data = q.pop_front();
            if (wacc) q.push_back(wr_data);
        end
    endtask

    task automatic checkOutput();
        int n;
        n = q.size();
        checkVal("std.count",        32'(s_count), 32'(n));
        checkVal("std.empty",        32'(s_empty), 32'(n == 0));
        checkVal("std.full",         32'(s_full),  32'(n == 8));
        checkVal("std.almost_empty", 32'(s_ae),    32'(n <= 1));
        checkVal("std.almost_full",  32'(s_af),    32'(n >= 7));
        checkVal("std.overflow",     32'(s_ovf),   32'(m_ovf));
        checkVal("std.underflow",    32'(s_unf),   32'(m_unf));
        checkVal("std.rd_valid",     32'(s_rd_valid), 32'(m_rd_valid));
        checkVal("std.rd_data",      32'(s_rd_data),  32'(m_rd_data));
        checkVal("fwft.count",       32'(f_count), 32'(n));
        checkVal("fwft.empty",       32'(f_empty), 32'(n == 0));
        checkVal("fwft.full",        32'(f_full),  32'(n == 8));
        checkVal("fwft.overflow",    32'(f_ovf),   32'(m_ovf));
        checkVal("fwft.underflow",   32'(f_unf),   32'(m_unf));
        checkVal("fwft.rd_valid",    32'(f_rd_valid), 32'(n > 0));
        if (n > 0) checkVal("fwft.rd_data", 32'(f_rd_data), 32'(q[0]));
    endtask

    task automatic applyStimulus(input logic r, input logic fl, input logic w,
                                 input logic [7:0] d, input logic rd, input logic clr);
        rst = r; flush = fl; wr_en = w; wr_data = d; rd_en = rd; clr_err = clr;
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput();
    endtask

    initial begin
        q.delete();
        m_ovf = 0; m_unf = 0; m_rd_valid = 0; m_rd_data = 8'h00;
        rst = 1; flush = 0; wr_en = 0; wr_data = 8'h00; rd_en = 0; clr_err = 0;

        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        applyStimulus(1, 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 8'(8'h10 + i), 0, 0);
        checkVal("fill.full", 32'(s_full), 32'd1);

        applyStimulus(0, 0, 1, 8'hAA, 1, 0);
        checkVal("both.count", 32'(s_count), 32'd8);

        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 8'h00, 1, 0);
        checkVal("drain.last", 32'(s_rd_data), 32'h0000_00AA);

        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 1, 8'h33, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 8'(8'h40 + i), 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        checkVal("clr.overflow", 32'(s_ovf), 32'd0);

        applyStimulus(0, 1, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 1, 8'h5A, 0, 0);
        checkVal("fwft.5a", 32'(f_rd_data), 32'h0000_005A);
        applyStimulus(0, 0, 0, 8'h00, 1, 0);

        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 8'(8'h60 + i), 0, 0);
        applyStimulus(0, 1, 1, 8'h99, 1, 0);

        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 60 : 35;
            applyStimulus(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < wp),
                          8'($urandom), ($urandom_range(0, 99) < 50),
                          ($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 8'($urandom), 0, 0);
        applyStimulus(1, 1, 1, 8'hFF, 1, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
